// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with an IF/ID pipeline register.
//
// States:
//   FETCH   | request outstanding at pc; a returning word goes to IF/ID
//   HOLD    | word arrived under stall; kept in a side buffer, no request
//   DISCARD | redirected with a request still in flight; its word is dropped
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stall                 hold IF/ID and pc
//   branch_taken/target   EX-stage branch redirect (wins over jump)
//   jump/jump_target      jump redirect
//   imem_req/addr         instruction read request, address
//   imem_ack/rdata        read completion, instruction word
//   pc                    current fetch address
//   if_id_instr/pc4/valid IF/ID pipeline register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] disc_addr;
  logic        ign_ack;

  logic        redirect;
  logic [31:0] target_sel;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ack;

  assign redirect   = branch_taken | jump;
  assign target_sel = branch_taken ? branch_target : jump_target;
  assign target     = target_sel & ~32'd3;
  assign pc_plus4   = pc + 32'd4;
  // The first cycle after reset may still see the ack of a request that
  // reset abandoned; it must not be taken as the answer to the new one.
  assign ack        = imem_ack & ~ign_ack;

  // In DISCARD the address of the dropped request is kept on the bus until
  // its ack, even though pc already points at the redirect target.
  assign imem_req  = (state != HOLD);
  assign imem_addr = (state == DISCARD) ? disc_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      buf_instr   <= 32'h0;
      buf_pc4     <= 32'h0;
      disc_addr   <= RESET_PC;
      ign_ack     <= 1'b1;
    end else begin
      ign_ack <= 1'b0;
      if (redirect) begin
        if_id_instr <= 32'h0;
        if_id_valid <= 1'b0;
        pc          <= target;
        case (state)
          FETCH: begin
            if (ack) begin
              state <= FETCH;
            end else begin
              state     <= DISCARD;
              disc_addr <= pc;
            end
          end
          HOLD:    state <= FETCH;
          DISCARD: state <= ack ? FETCH : DISCARD;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (stall) begin
              if (ack) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= pc_plus4;
                state     <= HOLD;
              end
            end else if (ack) begin
              if_id_instr <= imem_rdata;
              if_id_pc4   <= pc_plus4;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
            end else begin
              if_id_instr <= 32'h0;
              if_id_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              if_id_instr <= buf_instr;
              if_id_pc4   <= buf_pc4;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
              state       <= FETCH;
            end
          end
          DISCARD: begin
            if (!stall) begin
              if_id_instr <= 32'h0;
              if_id_valid <= 1'b0;
            end
            if (ack) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc, if_id_instr, if_id_pc4;

  logic        rst2, ack2, zero1;
  logic [31:0] rdata2, zero32;
  logic        req2, valid2;
  logic [31:0] addr2, pc2, instr2, pc4_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst2), .stall(zero1),
    .branch_taken(zero1), .branch_target(zero32),
    .jump(zero1), .jump_target(zero32),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .pc(pc2), .if_id_instr(instr2), .if_id_pc4(pc4_2),
    .if_id_valid(valid2)
  );

  // ctl = {stall, branch_taken, jump, imem_ack}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] epc4;
    logic        evalid;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; imem_rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{4'b0000, 32'h0,   32'h0,   32'h0,        1'b1, 32'h0,   32'h0,   32'h0,        32'h0,   1'b0};
    vt[1]  = '{4'b0001, 32'h0,   32'h0,   32'h20080005, 1'b1, 32'h0,   32'h4,   32'h20080005, 32'h4,   1'b1};
    vt[2]  = '{4'b0001, 32'h0,   32'h0,   32'h20090007, 1'b1, 32'h4,   32'h8,   32'h20090007, 32'h8,   1'b1};
    vt[3]  = '{4'b1001, 32'h0,   32'h0,   32'hAAAA0001, 1'b1, 32'h8,   32'h8,   32'h20090007, 32'h8,   1'b1};
    vt[4]  = '{4'b1000, 32'h0,   32'h0,   32'h0,        1'b0, 32'h0,   32'h8,   32'h20090007, 32'h8,   1'b1};
    vt[5]  = '{4'b1000, 32'h0,   32'h0,   32'h0,        1'b0, 32'h0,   32'h8,   32'h20090007, 32'h8,   1'b1};
    vt[6]  = '{4'b0000, 32'h0,   32'h0,   32'h0,        1'b0, 32'h0,   32'hC,   32'hAAAA0001, 32'hC,   1'b1};
    vt[7]  = '{4'b0000, 32'h0,   32'h0,   32'h0,        1'b1, 32'hC,   32'hC,   32'h0,        32'hC,   1'b0};
    vt[8]  = '{4'b0001, 32'h0,   32'h0,   32'h11110000, 1'b1, 32'hC,   32'h10,  32'h11110000, 32'h10,  1'b1};
    vt[9]  = '{4'b0100, 32'h43,  32'h0,   32'h0,        1'b1, 32'h10,  32'h40,  32'h0,        32'h10,  1'b0};
    vt[10] = '{4'b0000, 32'h0,   32'h0,   32'h0,        1'b1, 32'h10,  32'h40,  32'h0,        32'h10,  1'b0};
    vt[11] = '{4'b0001, 32'h0,   32'h0,   32'hDEADBEEF, 1'b1, 32'h10,  32'h40,  32'h0,        32'h10,  1'b0};
    vt[12] = '{4'b0000, 32'h0,   32'h0,   32'h0,        1'b1, 32'h40,  32'h40,  32'h0,        32'h10,  1'b0};
    vt[13] = '{4'b0111, 32'h100, 32'h200, 32'h12345678, 1'b1, 32'h40,  32'h100, 32'h0,        32'h10,  1'b0};
    vt[14] = '{4'b0010, 32'h0,   32'h203, 32'h0,        1'b1, 32'h100, 32'h200, 32'h0,        32'h10,  1'b0};
    vt[15] = '{4'b0001, 32'h0,   32'h0,   32'h0,        1'b1, 32'h100, 32'h200, 32'h0,        32'h10,  1'b0};
    vt[16] = '{4'b0001, 32'h0,   32'h0,   32'h3C010001, 1'b1, 32'h200, 32'h204, 32'h3C010001, 32'h204, 1'b1};
    vt[17] = '{4'b1000, 32'h0,   32'h0,   32'h0,        1'b1, 32'h204, 32'h204, 32'h3C010001, 32'h204, 1'b1};
    vt[18] = '{4'b1001, 32'h0,   32'h0,   32'h55,       1'b1, 32'h204, 32'h204, 32'h3C010001, 32'h204, 1'b1};
    vt[19] = '{4'b1010, 32'h0,   32'h300, 32'h0,        1'b0, 32'h0,   32'h300, 32'h0,        32'h204, 1'b0};
    vt[20] = '{4'b0001, 32'h0,   32'h0,   32'h77,       1'b1, 32'h300, 32'h304, 32'h77,       32'h304, 1'b1};

    zero1 = 1'b0; zero32 = 32'h0;
    rst2 = 1'b1; ack2 = 1'b0; rdata2 = 32'h0;
    clr_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pc",    pc,                  32'h0);
    chk("rst_instr", if_id_instr,         32'h0);
    chk("rst_pc4",   if_id_pc4,           32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      stall         = vt[i].ctl[3];
      branch_taken  = vt[i].ctl[2];
      jump          = vt[i].ctl[1];
      imem_ack      = vt[i].ctl[0];
      branch_target = vt[i].bt;
      jump_target   = vt[i].jt;
      imem_rdata    = vt[i].rd;
      #2;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].ereq});
      if (vt[i].ereq) chk($sformatf("v%0d_addr", i), imem_addr, vt[i].eaddr);
      tick();
      chk($sformatf("v%0d_pc", i),    pc,                   vt[i].epc);
      chk($sformatf("v%0d_instr", i), if_id_instr,          vt[i].einstr);
      chk($sformatf("v%0d_pc4", i),   if_id_pc4,            vt[i].epc4);
      chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vt[i].evalid});
    end

    // reset while a dropped request is in flight, stale ack right after reset
    clr_inputs();
    branch_taken = 1'b1; branch_target = 32'h500;
    tick();
    chk("disc_pc", pc, 32'h500);
    clr_inputs();
    #2;
    chk("disc_addr", imem_addr, 32'h304);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h99;
    #2;
    chk("prst_req",  {31'b0, imem_req}, 32'h1);
    chk("prst_addr", imem_addr,         32'h0);
    tick();
    chk("prst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("prst_instr", if_id_instr,          32'h0);
    chk("prst_pc",    pc,                   32'h0);
    imem_rdata = 32'h42;
    tick();
    chk("prst2_valid", {31'b0, if_id_valid}, 32'h1);
    chk("prst2_instr", if_id_instr,          32'h42);
    chk("prst2_pc4",   if_id_pc4,            32'h4);
    clr_inputs();

    // pc wrap with RESET_PC at the top of the address space
    rst2 = 1'b0;
    #2;
    chk("wrap_req0",  {31'b0, req2}, 32'h1);
    chk("wrap_addr0", addr2,         32'hFFFF_FFFC);
    tick();
    ack2 = 1'b1; rdata2 = 32'h1234;
    tick();
    ack2 = 1'b0;
    chk("wrap_pc4",   pc4_2,           32'h0);
    chk("wrap_valid", {31'b0, valid2}, 32'h1);
    chk("wrap_instr", instr2,          32'h1234);
    #2;
    chk("wrap_addr1", addr2,           32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
